// File: rtl/if_id_pipe_reg.sv
// IF->ID pipeline register with valid/ready handshake, flush-to-NOP and an
// optional 2-entry skid buffer selected by the IF_ID_SKID_EN macro.
module if_id_pipe_reg #(
  parameter int                INST_W   = 32,
  parameter int                ADDR_W   = 32,
  parameter logic [INST_W-1:0] NOP_INST = 32'h00000013,
  parameter logic [ADDR_W-1:0] RST_ADDR = 32'h00000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [INST_W-1:0] in_inst,
  input  logic [ADDR_W-1:0] in_addr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [INST_W-1:0] out_inst,
  output logic [ADDR_W-1:0] out_addr,
  output logic [1:0]        occ
);

  // Handshake: a beat moves only when valid & ready are both high on a rising
  // edge; a producer holding valid keeps its payload stable until it moves.
  logic              vm;
  logic [INST_W-1:0] im;
  logic [ADDR_W-1:0] am;
  logic              acc;
  logic              fire;
  logic              m_free;

  assign acc       = in_valid & in_ready;
  assign fire      = vm & out_ready;
  assign m_free    = ~vm | fire;
  assign out_valid = vm;
  assign out_inst  = vm ? im : NOP_INST;
  assign out_addr  = am;

`ifdef IF_ID_SKID_EN
  logic              vs;
  logic [INST_W-1:0] is_q;
  logic [ADDR_W-1:0] as_q;
  logic              rdy_q;

  // Ready is a flop tracking !vs, so out_ready never reaches in_ready.
  assign in_ready = rdy_q;
  assign occ      = {1'b0, vm} + {1'b0, vs};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vm    <= 1'b0;
      im    <= NOP_INST;
      am    <= RST_ADDR;
      vs    <= 1'b0;
      is_q  <= NOP_INST;
      as_q  <= RST_ADDR;
      rdy_q <= 1'b0;
    end else if (flush) begin
      vm    <= 1'b0;
      im    <= NOP_INST;
      am    <= RST_ADDR;
      vs    <= 1'b0;
      is_q  <= NOP_INST;
      as_q  <= RST_ADDR;
      rdy_q <= 1'b1;
    end else if (m_free) begin
      if (vs) begin
        // Older skid entry moves up first to keep FIFO order.
        vm    <= 1'b1;
        im    <= is_q;
        am    <= as_q;
        vs    <= acc;
        rdy_q <= ~acc;
        if (acc) begin
          is_q <= in_inst;
          as_q <= in_addr;
        end
      end else if (acc) begin
        vm    <= 1'b1;
        im    <= in_inst;
        am    <= in_addr;
        rdy_q <= 1'b1;
      end else begin
        vm    <= 1'b0;
        rdy_q <= 1'b1;
      end
    end else if (acc) begin
      vs    <= 1'b1;
      is_q  <= in_inst;
      as_q  <= in_addr;
      rdy_q <= 1'b0;
    end else begin
      rdy_q <= ~vs;
    end
  end
`else
  assign in_ready = ~vm | out_ready;
  assign occ      = {1'b0, vm};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vm <= 1'b0;
      im <= NOP_INST;
      am <= RST_ADDR;
    end else if (flush) begin
      vm <= 1'b0;
      im <= NOP_INST;
      am <= RST_ADDR;
    end else if (m_free) begin
      vm <= acc;
      if (acc) begin
        im <= in_inst;
        am <= in_addr;
      end
    end
  end
`endif

endmodule

// File: tb/tb_if_id_pipe_reg.sv
// Bench for if_id_pipe_reg: queue-based reference model of the stage contents,
// directed scenarios plus randomized traffic; build with or without IF_ID_SKID_EN.
`timescale 1ns/1ps
module tb_if_id_pipe_reg;
  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_inst;
  logic [31:0] in_addr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_addr;
  logic [1:0]  occ;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];
  logic [31:0] got[$];
  bit          armed = 1'b0;

  always #5 clk = ~clk;

  if_id_pipe_reg dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_addr(in_addr),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
    .out_addr(out_addr), .occ(occ)
  );

  // Model view: the stage is a FIFO of at most 2 (skid) or 1 entries.
  function automatic logic m_ready();
`ifdef IF_ID_SKID_EN
    return armed && (exp_q.size() < 2);
`else
    return (exp_q.size() == 0) || out_ready;
`endif
  endfunction

  function automatic logic [67:0] exp_obs();
    logic [63:0] h;
    logic        v;
    v = exp_q.size() != 0;
    h = {NOP, 32'h0};
    if (v) h = exp_q[0];
    return {v, h[63:32], h[31:0], 2'(exp_q.size()), m_ready()};
  endfunction

  function automatic logic [67:0] obs_vec();
    return {out_valid, out_inst, (exp_q.size() != 0) ? out_addr : 32'h0, occ, in_ready};
  endfunction

  task automatic drive(input logic iv, input logic [31:0] ii, input logic [31:0] ia,
                       input logic ordy, input logic fl);
    in_valid  = iv;
    in_inst   = ii;
    in_addr   = ia;
    out_ready = ordy;
    flush     = fl;
  endtask

  // Advance one clock; the model applies the accepted/delivered events.
  task automatic tick(output logic acc);
    logic fire;
    acc  = in_valid && m_ready();
    fire = (exp_q.size() != 0) && out_ready;
    @(posedge clk);
    if (flush) exp_q.delete();
    else begin
      if (fire) void'(exp_q.pop_front());
      if (acc) exp_q.push_back({in_inst, in_addr});
    end
    armed = 1'b1;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    logic a;
    for (int k = 0; k < n; k++) begin
      drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      tick(a);
    end
  endtask

  task automatic test_reset();
    logic a;
    @(negedge clk);
    @(negedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0b want=0", out_valid); end
    checks++; if (out_inst !== NOP) begin errors++; $display("FAIL reset_inst got=%h want=%h", out_inst, NOP); end
    checks++; if (out_addr !== 32'h0) begin errors++; $display("FAIL reset_addr got=%h want=0", out_addr); end
    checks++; if (occ !== 2'd0) begin errors++; $display("FAIL reset_occ got=%0d want=0", occ); end
    @(negedge clk);
    rst = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    #1;
    checks++;
    if (obs_vec() !== exp_obs()) begin errors++; $display("FAIL reset_release dut=%h model=%h", obs_vec(), exp_obs()); end
    tick(a);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%0b want=1", in_ready); end
  endtask

  task automatic test_streaming();
    logic [31:0] pend[$];
    logic [31:0] nxt;
    logic        a;
    idle(3);
    got.delete();
    for (int k = 0; k < 8; k++) pend.push_back(32'h100 + 32'(4 * k));
    for (int c = 0; c < 12; c++) begin
      nxt = 32'h0;
      if (pend.size() != 0) nxt = pend[0];
      drive(pend.size() != 0, $urandom, nxt, 1'b1, 1'b0);
      #1;
      checks++;
      if (obs_vec() !== exp_obs()) begin errors++; $display("FAIL stream c%0d dut=%h model=%h", c, obs_vec(), exp_obs()); end
      if (out_valid && out_ready) got.push_back(out_addr);
      tick(a);
      if (a) void'(pend.pop_front());
    end
    checks++; if (got.size() != 8) begin errors++; $display("FAIL stream_count got=%0d want=8", got.size()); end
    for (int k = 0; k < got.size() && k < 8; k++) begin
      checks++;
      if (got[k] !== 32'h100 + 32'(4 * k)) begin errors++; $display("FAIL stream_order k%0d got=%h want=%h", k, got[k], 32'h100 + 32'(4 * k)); end
    end
  endtask

  task automatic test_stall();
    logic [31:0] pend[$];
    logic [31:0] nxt;
    logic        a;
    idle(3);
    got.delete();
    pend.push_back(32'h100);
    pend.push_back(32'h104);
    for (int c = 0; c < 10; c++) begin
      nxt = 32'h0;
      if (pend.size() != 0) nxt = pend[0];
      drive(pend.size() != 0, $urandom, nxt, c >= 4, 1'b0);
      #1;
      checks++;
      if (obs_vec() !== exp_obs()) begin errors++; $display("FAIL stall c%0d dut=%h model=%h", c, obs_vec(), exp_obs()); end
      if (c == 4) begin
`ifdef IF_ID_SKID_EN
        checks++; if (occ !== 2'd2) begin errors++; $display("FAIL stall_occ got=%0d want=2", occ); end
`else
        checks++; if (occ !== 2'd1) begin errors++; $display("FAIL stall_occ got=%0d want=1", occ); end
`endif
        checks++; if (out_addr !== 32'h100) begin errors++; $display("FAIL stall_hold got=%h want=100", out_addr); end
      end
      if (c == 3) begin
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_ready got=%0b want=0", in_ready); end
      end
      if (out_valid && out_ready) got.push_back(out_addr);
      tick(a);
      if (a) void'(pend.pop_front());
    end
    checks++;
    if (got.size() != 2 || got[0] !== 32'h100 || got[1] !== 32'h104) begin
      errors++; $display("FAIL stall_order got_n=%0d want 100,104", got.size());
    end
  endtask

  task automatic test_flush();
    logic a;
    idle(3);
    for (int c = 0; c < 2; c++) begin
      drive(1'b1, $urandom, 32'h100 + 32'(4 * c), 1'b0, 1'b0);
      #1;
      checks++;
      if (obs_vec() !== exp_obs()) begin errors++; $display("FAIL flush_fill c%0d dut=%h model=%h", c, obs_vec(), exp_obs()); end
      tick(a);
    end
    drive(1'b1, $urandom, 32'h108, 1'b0, 1'b1);
    tick(a);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got=%0b want=0", out_valid); end
    checks++; if (out_inst !== NOP) begin errors++; $display("FAIL flush_inst got=%h want=%h", out_inst, NOP); end
    checks++; if (occ !== 2'd0) begin errors++; $display("FAIL flush_occ got=%0d want=0", occ); end
    checks++; if (out_addr !== 32'h0) begin errors++; $display("FAIL flush_addr got=%h want=0", out_addr); end
    for (int c = 0; c < 4; c++) begin
      tick(a);
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_leak c%0d addr=%h want none", c, out_addr); end
    end
  endtask

  task automatic test_full_fire();
    logic [31:0] pend[$];
    logic [31:0] nxt;
    logic        a;
    idle(3);
    got.delete();
    pend.push_back(32'h100);
    pend.push_back(32'h104);
    pend.push_back(32'h108);
    for (int c = 0; c < 9; c++) begin
      nxt = 32'h0;
      if (pend.size() != 0) nxt = pend[0];
      drive(pend.size() != 0, $urandom, nxt, c >= 2, 1'b0);
      #1;
      checks++;
      if (obs_vec() !== exp_obs()) begin errors++; $display("FAIL fullfire c%0d dut=%h model=%h", c, obs_vec(), exp_obs()); end
`ifdef IF_ID_SKID_EN
      if (c == 2) begin
        checks++; if (occ !== 2'd2) begin errors++; $display("FAIL fullfire_occ got=%0d want=2", occ); end
      end
`endif
      if (out_valid && out_ready) got.push_back(out_addr);
      tick(a);
      if (a) void'(pend.pop_front());
    end
    checks++;
    if (got.size() != 3 || got[0] !== 32'h100 || got[1] !== 32'h104 || got[2] !== 32'h108) begin
      errors++; $display("FAIL fullfire_order got_n=%0d want 100,104,108", got.size());
    end
  endtask

  task automatic test_async_reset();
    logic a;
    idle(2);
    for (int c = 0; c < 4; c++) begin
      drive(1'b1, $urandom, 32'h300 + 32'(4 * c), 1'b1, 1'b0);
      tick(a);
    end
    drive(1'b1, $urandom, 32'h310, 1'b0, 1'b0);
    #3 rst = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL areset_valid got=%0b want=0", out_valid); end
    checks++; if (out_inst !== NOP) begin errors++; $display("FAIL areset_inst got=%h want=%h", out_inst, NOP); end
    checks++; if (out_addr !== 32'h0) begin errors++; $display("FAIL areset_addr got=%h want=0", out_addr); end
    checks++; if (occ !== 2'd0) begin errors++; $display("FAIL areset_occ got=%0d want=0", occ); end
    exp_q.delete();
    armed = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    #1;
    checks++;
    if (obs_vec() !== exp_obs()) begin errors++; $display("FAIL areset_release dut=%h model=%h", obs_vec(), exp_obs()); end
    tick(a);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL areset_ready got=%0b want=1", in_ready); end
  endtask

  task automatic test_random();
    logic a;
    for (int c = 0; c < 400; c++) begin
      drive($urandom_range(0, 1), $urandom, $urandom, $urandom_range(0, 9) < 7,
            $urandom_range(0, 19) == 0);
      #1;
      checks++;
      if (obs_vec() !== exp_obs()) begin errors++; $display("FAIL random c%0d dut=%h model=%h", c, obs_vec(), exp_obs()); end
      tick(a);
    end
  endtask

  initial begin
    rst = 1'b0;
    drive(1'b1, $urandom, 32'h200, 1'b0, 1'b0);
    test_reset();
    test_streaming();
    test_stall();
    test_flush();
    test_full_fire();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
